// File: rtl/gen_reg_file_pkg.sv
// Shared defaults and helpers for the general register file slice:
// index width derivation, IR field positions and the selection source type.
package gen_reg_file_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_NREGS    = 16;
    localparam int DEF_IR_WIDTH = 32;
    localparam int DEF_RA_LSB   = 23;
    localparam int DEF_RB_LSB   = 19;
    localparam int DEF_RC_LSB   = 15;
    localparam int DEF_C_WIDTH  = 19;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_RA   = 2'd1,
        SRC_RB   = 2'd2,
        SRC_RC   = 2'd3
    } sel_src_e;

    // Register index width; never narrower than one bit.
    function automatic int idx_width(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/gen_reg_file_if.sv
// Control, bus and read-port bundle between the control unit/datapath and the
// general register file.
interface gen_reg_file_if
    import gen_reg_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int IR_WIDTH = DEF_IR_WIDTH,
    parameter int RW       = idx_width(DEF_NREGS)
) ();
    logic [IR_WIDTH-1:0] ir;
    logic                gra;
    logic                grb;
    logic                grc;
    logic                rin;
    logic                rout;
    logic                baout;
    logic                pend_set;
    logic [WIDTH-1:0]    bus_in;
    logic [RW-1:0]       rd2_idx;
    logic [WIDTH-1:0]    bus_out;
    logic                bus_out_en;
    logic [WIDTH-1:0]    rd2_data;
    logic                stall;
    logic                illegal_sel;
    logic [WIDTH-1:0]    c_sign_extended;

    modport master (
        output ir, gra, grb, grc, rin, rout, baout, pend_set, bus_in, rd2_idx,
        input  bus_out, bus_out_en, rd2_data, stall, illegal_sel, c_sign_extended
    );

    modport slave (
        input  ir, gra, grb, grc, rin, rout, baout, pend_set, bus_in, rd2_idx,
        output bus_out, bus_out_en, rd2_data, stall, illegal_sel, c_sign_extended
    );
endinterface

// File: rtl/gen_sel_encode.sv
// Register select/encode: gr* priority, Ra/Rb/Rc extraction, range check and
// one-hot write, read and pending-set enables.
module gen_sel_encode
    import gen_reg_file_pkg::*;
#(
    parameter int NREGS    = DEF_NREGS,
    parameter int IR_WIDTH = DEF_IR_WIDTH,
    parameter int RA_LSB   = DEF_RA_LSB,
    parameter int RB_LSB   = DEF_RB_LSB,
    parameter int RC_LSB   = DEF_RC_LSB,
    parameter int RW       = idx_width(DEF_NREGS)
) (
    input  logic [IR_WIDTH-1:0] ir,
    input  logic                gra,
    input  logic                grb,
    input  logic                grc,
    input  logic                rin,
    input  logic                rout,
    input  logic                baout,
    input  logic                pend_set,
    output logic [RW-1:0]       sel_idx,
    output logic                sel_valid,
    output logic                illegal_sel,
    output logic [NREGS-1:0]    wr_en,
    output logic [NREGS-1:0]    rd_en,
    output logic [NREGS-1:0]    pend_en
);
    // One extra bit so the range compare is meaningful when NREGS is a power of 2.
    localparam logic [RW:0] NREGS_W = (RW+1)'(NREGS);

    sel_src_e src_s;
    logic     unused_ir_s;

    assign unused_ir_s = ^ir;

    // Field source priority and index extraction.
    always_comb begin
        src_s = SRC_NONE;
        if (gra) begin
            src_s = SRC_RA;
        end else if (grb) begin
            src_s = SRC_RB;
        end else if (grc) begin
            src_s = SRC_RC;
        end else begin
            src_s = SRC_NONE;
        end
        case (src_s)
            SRC_RA:  sel_idx = ir[RA_LSB +: RW];
            SRC_RB:  sel_idx = ir[RB_LSB +: RW];
            SRC_RC:  sel_idx = ir[RC_LSB +: RW];
            default: sel_idx = {RW{1'b0}};
        endcase
        illegal_sel = (src_s != SRC_NONE) && ({1'b0, sel_idx} >= NREGS_W);
        sel_valid   = (src_s != SRC_NONE) && !illegal_sel;
    end

    // One-hot enables; an illegal or absent selection hits nothing.
    always_comb begin
        wr_en   = {NREGS{1'b0}};
        rd_en   = {NREGS{1'b0}};
        pend_en = {NREGS{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            wr_en[i]   = sel_valid && (sel_idx == RW'(i)) && rin;
            rd_en[i]   = sel_valid && (sel_idx == RW'(i)) && (rout || baout);
            pend_en[i] = sel_valid && (sel_idx == RW'(i)) && pend_set;
        end
    end

endmodule

// File: rtl/gen_reg_file.sv
// Parametrised general register file: NREGS x WIDTH array with bus read/write,
// second read port with optional bypass, load-pending scoreboard and C-field extension.
module gen_reg_file
    import gen_reg_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NREGS    = DEF_NREGS,
    parameter int IR_WIDTH = DEF_IR_WIDTH,
    parameter int RA_LSB   = DEF_RA_LSB,
    parameter int RB_LSB   = DEF_RB_LSB,
    parameter int RC_LSB   = DEF_RC_LSB,
    parameter int C_WIDTH  = DEF_C_WIDTH,
    parameter int ZERO_R0  = 1,
    parameter int BYPASS   = 1
) (
    input logic            clk,
    input logic            clr,
    gen_reg_file_if.slave  bus
);
    localparam int RW = idx_width(NREGS);

    if (C_WIDTH > WIDTH || C_WIDTH < 1) begin : g_bad_c_width
        $error("gen_reg_file: C_WIDTH must be in 1..WIDTH");
    end
    if (NREGS < 2 || NREGS > 32) begin : g_bad_nregs
        $error("gen_reg_file: NREGS must be in 2..32");
    end

    logic [WIDTH-1:0] reg_q [NREGS];
    logic [WIDTH-1:0] reg_d [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    logic [RW-1:0]    sel_idx_s;
    logic             sel_valid_s;
    logic             illegal_s;
    logic [NREGS-1:0] wr_en_s;
    logic [NREGS-1:0] rd_en_s;
    logic [NREGS-1:0] pend_en_s;
    logic [WIDTH-1:0] bus_rd_s;
    logic [WIDTH-1:0] rd2_s;
    logic             rd2_pend_s;
    logic [WIDTH-1:0] c_ext_s;

    // Gating the selects with clr forces every status output low during reset.
    gen_sel_encode #(
        .NREGS(NREGS), .IR_WIDTH(IR_WIDTH), .RA_LSB(RA_LSB),
        .RB_LSB(RB_LSB), .RC_LSB(RC_LSB), .RW(RW)
    ) u_sel (
        .ir(bus.ir), .gra(bus.gra & clr), .grb(bus.grb & clr), .grc(bus.grc & clr),
        .rin(bus.rin), .rout(bus.rout), .baout(bus.baout), .pend_set(bus.pend_set),
        .sel_idx(sel_idx_s), .sel_valid(sel_valid_s), .illegal_sel(illegal_s),
        .wr_en(wr_en_s), .rd_en(rd_en_s), .pend_en(pend_en_s)
    );

    // Next state: a pend_set on the same edge as a write keeps the register pending.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            reg_d[i]  = wr_en_s[i] ? bus.bus_in : reg_q[i];
            pend_d[i] = pend_en_s[i] | (pend_q[i] & ~wr_en_s[i]);
        end
    end

    // Register array and scoreboard state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NREGS; i++) begin
                reg_q[i] <= {WIDTH{1'b0}};
            end
            pend_q <= {NREGS{1'b0}};
        end else begin
            reg_q  <= reg_d;
            pend_q <= pend_d;
        end
    end

    // Read muxes for the bus and port 2.
    always_comb begin
        bus_rd_s   = {WIDTH{1'b0}};
        rd2_s      = {WIDTH{1'b0}};
        rd2_pend_s = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            bus_rd_s   = bus_rd_s |
                         ((rd_en_s[i] && !((ZERO_R0 != 0) && (i == 0) && bus.baout))
                          ? reg_q[i] : {WIDTH{1'b0}});
            rd2_s      = rd2_s | ((bus.rd2_idx == RW'(i)) ? reg_q[i] : {WIDTH{1'b0}});
            rd2_pend_s = rd2_pend_s | ((bus.rd2_idx == RW'(i)) && pend_q[i]);
        end
        if ((BYPASS != 0) && (|wr_en_s) && (sel_idx_s == bus.rd2_idx)) begin
            rd2_s = bus.bus_in;
        end else begin
            rd2_s = rd2_s;
        end
    end

    if (C_WIDTH == WIDTH) begin : g_c_full
        assign c_ext_s = bus.ir[C_WIDTH-1:0];
    end else begin : g_c_ext
        assign c_ext_s = {{(WIDTH-C_WIDTH){bus.ir[C_WIDTH-1]}}, bus.ir[C_WIDTH-1:0]};
    end

    assign bus.bus_out         = bus_rd_s;
    assign bus.bus_out_en      = |rd_en_s;
    assign bus.rd2_data        = rd2_s;
    assign bus.stall           = (|(rd_en_s & pend_q)) | rd2_pend_s;
    assign bus.illegal_sel     = illegal_s;
    assign bus.c_sign_extended = clr ? c_ext_s : {WIDTH{1'b0}};

    logic unused_sel_valid_s;
    assign unused_sel_valid_s = sel_valid_s;

endmodule

// File: tb/tb_gen_reg_file.sv
// Directed bench for gen_reg_file: default build plus ZERO_R0=0 and NREGS=12 builds
// driven by one stimulus stream; table of single-cycle vectors then corner sequences.
module tb_gen_reg_file;
    import gen_reg_file_pkg::*;

    typedef struct {
        logic [2:0]  gr;
        logic [3:0]  ra, rb, rc;
        logic        rin, rout, baout, pset;
        logic [31:0] din;
        logic [3:0]  rd2;
        logic [31:0] e_bus;
        logic        e_en;
        logic [31:0] e_rd2;
        logic        e_stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic        gra, grb, grc, rin, rout, baout, pend_set;
    logic [31:0] bus_in;
    logic [3:0]  rd2_idx;

    int n_checks = 0;
    int n_err    = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    gen_reg_file_if #(.WIDTH(32), .IR_WIDTH(32), .RW(4)) if_main ();
    gen_reg_file_if #(.WIDTH(32), .IR_WIDTH(32), .RW(4)) if_z0 ();
    gen_reg_file_if #(.WIDTH(32), .IR_WIDTH(32), .RW(4)) if_n12 ();

    always_comb begin
        if_main.ir = ir; if_main.gra = gra; if_main.grb = grb; if_main.grc = grc;
        if_main.rin = rin; if_main.rout = rout; if_main.baout = baout;
        if_main.pend_set = pend_set; if_main.bus_in = bus_in; if_main.rd2_idx = rd2_idx;
    end
    always_comb begin
        if_z0.ir = ir; if_z0.gra = gra; if_z0.grb = grb; if_z0.grc = grc;
        if_z0.rin = rin; if_z0.rout = rout; if_z0.baout = baout;
        if_z0.pend_set = pend_set; if_z0.bus_in = bus_in; if_z0.rd2_idx = rd2_idx;
    end
    always_comb begin
        if_n12.ir = ir; if_n12.gra = gra; if_n12.grb = grb; if_n12.grc = grc;
        if_n12.rin = rin; if_n12.rout = rout; if_n12.baout = baout;
        if_n12.pend_set = pend_set; if_n12.bus_in = bus_in; if_n12.rd2_idx = rd2_idx;
    end

    gen_reg_file u_main (.clk(clk), .clr(clr), .bus(if_main));
    gen_reg_file #(.ZERO_R0(0)) u_z0 (.clk(clk), .clr(clr), .bus(if_z0));
    gen_reg_file #(.NREGS(12)) u_n12 (.clk(clk), .clr(clr), .bus(if_n12));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] g, input logic [3:0] a, b, c,
                                input logic wi, ro, ba, ps, input logic [31:0] d,
                                input logic [3:0] r2, input logic [31:0] eb,
                                input logic ee, input logic [31:0] er, input logic es);
        vec_t v;
        v.gr = g; v.ra = a; v.rb = b; v.rc = c; v.rin = wi; v.rout = ro; v.baout = ba;
        v.pset = ps; v.din = d; v.rd2 = r2; v.e_bus = eb; v.e_en = ee; v.e_rd2 = er;
        v.e_stall = es;
        return v;
    endfunction

    task automatic drive(input logic [2:0] g, input logic [3:0] a, b, c,
                         input logic wi, ro, ba, ps, input logic [31:0] d,
                         input logic [3:0] r2);
        ir = (32'(a) << 23) | (32'(b) << 19) | (32'(c) << 15);
        {gra, grb, grc} = g;
        rin = wi; rout = ro; baout = ba; pend_set = ps; bus_in = d; rd2_idx = r2;
    endtask

    initial begin
        // Cycle-by-cycle table; expected values are taken just before each edge.
        vecs.push_back(mk(3'b100, 4'd3, 4'd0, 4'd0, 1, 0, 0, 0, 32'h12345678, 4'd3, 32'h0, 0, 32'h12345678, 0));
        vecs.push_back(mk(3'b100, 4'd3, 4'd0, 4'd0, 0, 1, 0, 0, 32'h0, 4'd3, 32'h12345678, 1, 32'h12345678, 0));
        vecs.push_back(mk(3'b100, 4'd0, 4'd0, 4'd0, 1, 0, 0, 0, 32'hFFFF0000, 4'd1, 32'h0, 0, 32'h0, 0));
        vecs.push_back(mk(3'b100, 4'd0, 4'd0, 4'd0, 0, 1, 0, 0, 32'h0, 4'd0, 32'hFFFF0000, 1, 32'hFFFF0000, 0));
        vecs.push_back(mk(3'b100, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0, 32'h0, 4'd0, 32'h0, 1, 32'hFFFF0000, 0));
        vecs.push_back(mk(3'b100, 4'd0, 4'd0, 4'd0, 0, 1, 1, 0, 32'h0, 4'd3, 32'h0, 1, 32'h12345678, 0));
        vecs.push_back(mk(3'b100, 4'd3, 4'd0, 4'd0, 0, 0, 1, 0, 32'h0, 4'd0, 32'h12345678, 1, 32'hFFFF0000, 0));
        vecs.push_back(mk(3'b110, 4'd2, 4'd7, 4'd0, 1, 0, 0, 0, 32'h22222222, 4'd7, 32'h0, 0, 32'h0, 0));
        vecs.push_back(mk(3'b010, 4'd2, 4'd7, 4'd0, 0, 1, 0, 0, 32'h0, 4'd2, 32'h0, 1, 32'h22222222, 0));
        vecs.push_back(mk(3'b110, 4'd2, 4'd7, 4'd0, 0, 1, 0, 0, 32'h0, 4'd7, 32'h22222222, 1, 32'h0, 0));
        vecs.push_back(mk(3'b001, 4'd0, 4'd0, 4'd5, 0, 1, 0, 0, 32'h0, 4'd0, 32'h0, 1, 32'hFFFF0000, 0));
        vecs.push_back(mk(3'b000, 4'd6, 4'd0, 4'd0, 1, 1, 0, 0, 32'hBAD00000, 4'd6, 32'h0, 0, 32'h0, 0));
        vecs.push_back(mk(3'b100, 4'd6, 4'd0, 4'd0, 0, 1, 0, 0, 32'h0, 4'd6, 32'h0, 1, 32'h0, 0));
        vecs.push_back(mk(3'b100, 4'd4, 4'd0, 4'd0, 0, 0, 0, 1, 32'h0, 4'd0, 32'h0, 0, 32'hFFFF0000, 0));
        vecs.push_back(mk(3'b100, 4'd4, 4'd0, 4'd0, 0, 1, 0, 0, 32'h0, 4'd0, 32'h0, 1, 32'hFFFF0000, 1));
        vecs.push_back(mk(3'b100, 4'd4, 4'd0, 4'd0, 0, 0, 0, 0, 32'h0, 4'd4, 32'h0, 0, 32'h0, 1));
        vecs.push_back(mk(3'b100, 4'd4, 4'd0, 4'd0, 1, 1, 0, 0, 32'hA5A5A5A5, 4'd4, 32'h0, 1, 32'hA5A5A5A5, 1));
        vecs.push_back(mk(3'b100, 4'd4, 4'd0, 4'd0, 0, 1, 0, 0, 32'h0, 4'd4, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 0));
        vecs.push_back(mk(3'b100, 4'd4, 4'd0, 4'd0, 1, 0, 0, 1, 32'h5A5A5A5A, 4'd0, 32'h0, 0, 32'hFFFF0000, 0));
        vecs.push_back(mk(3'b100, 4'd4, 4'd0, 4'd0, 0, 1, 0, 0, 32'h0, 4'd0, 32'h5A5A5A5A, 1, 32'hFFFF0000, 1));
        vecs.push_back(mk(3'b100, 4'd4, 4'd0, 4'd0, 1, 0, 0, 0, 32'h44444444, 4'd3, 32'h0, 0, 32'h12345678, 0));
        vecs.push_back(mk(3'b100, 4'd9, 4'd0, 4'd0, 1, 0, 0, 0, 32'h00000055, 4'd9, 32'h0, 0, 32'h00000055, 0));
        vecs.push_back(mk(3'b100, 4'd9, 4'd0, 4'd0, 0, 1, 0, 0, 32'h0, 4'd9, 32'h00000055, 1, 32'h00000055, 0));
        vecs.push_back(mk(3'b000, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 32'h0, 4'd15, 32'h0, 0, 32'h0, 0));
        vecs.push_back(mk(3'b100, 4'd4, 4'd0, 4'd0, 0, 1, 0, 0, 32'h0, 4'd4, 32'h44444444, 1, 32'h44444444, 0));

        // Reset state, with selects active to show they are masked.
        clr = 1'b0;
        drive(3'b100, 4'd3, 4'd0, 4'd0, 0, 1, 0, 0, 32'h0, 4'd3);
        ir = 32'h00040000;
        #2;
        chk("rst bus_out", if_main.bus_out, 32'h0);
        chk("rst bus_out_en", 32'(if_main.bus_out_en), 32'h0);
        chk("rst stall", 32'(if_main.stall), 32'h0);
        chk("rst illegal_sel", 32'(if_main.illegal_sel), 32'h0);
        chk("rst rd2_data", if_main.rd2_data, 32'h0);
        chk("rst c_sign_extended", if_main.c_sign_extended, 32'h0);
        @(negedge clk);
        drive(3'b000, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 32'h0, 4'd0);
        clr = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].gr, vecs[i].ra, vecs[i].rb, vecs[i].rc, vecs[i].rin, vecs[i].rout,
                  vecs[i].baout, vecs[i].pset, vecs[i].din, vecs[i].rd2);
            #1;
            chk($sformatf("v%0d bus_out", i), if_main.bus_out, vecs[i].e_bus);
            chk($sformatf("v%0d bus_out_en", i), 32'(if_main.bus_out_en), 32'(vecs[i].e_en));
            chk($sformatf("v%0d rd2_data", i), if_main.rd2_data, vecs[i].e_rd2);
            chk($sformatf("v%0d stall", i), 32'(if_main.stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d illegal_sel", i), 32'(if_main.illegal_sel), 32'h0);
        end

        // R0 under baout: zeroed in the default build, stored value with ZERO_R0=0.
        @(negedge clk);
        drive(3'b100, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0, 32'h0, 4'd0);
        #1;
        chk("baout r0 main", if_main.bus_out, 32'h0);
        chk("baout r0 z0", if_z0.bus_out, 32'hFFFF0000);
        chk("baout r0 z0 en", 32'(if_z0.bus_out_en), 32'h1);

        // Out-of-range Rc on the 12-register build; the 16-register build accepts it.
        @(negedge clk);
        drive(3'b001, 4'd0, 4'd0, 4'd14, 1, 0, 0, 0, 32'h00000077, 4'd14);
        #1;
        chk("n12 wr illegal_sel", 32'(if_n12.illegal_sel), 32'h1);
        chk("n12 wr rd2_data", if_n12.rd2_data, 32'h0);
        chk("main r14 bypass", if_main.rd2_data, 32'h00000077);
        chk("main r14 illegal_sel", 32'(if_main.illegal_sel), 32'h0);
        @(negedge clk);
        drive(3'b001, 4'd0, 4'd0, 4'd14, 0, 1, 0, 0, 32'h0, 4'd14);
        #1;
        chk("n12 rd illegal_sel", 32'(if_n12.illegal_sel), 32'h1);
        chk("n12 rd bus_out", if_n12.bus_out, 32'h0);
        chk("n12 rd bus_out_en", 32'(if_n12.bus_out_en), 32'h0);
        chk("n12 rd stall", 32'(if_n12.stall), 32'h0);
        chk("main r14 bus_out", if_main.bus_out, 32'h00000077);

        // C field sign extension.
        @(negedge clk);
        drive(3'b000, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 32'h0, 4'd0);
        ir = 32'h00040000; #1;
        chk("cext neg", if_main.c_sign_extended, 32'hFFFC0000);
        ir = 32'h0003FFFF; #1;
        chk("cext pos", if_main.c_sign_extended, 32'h0003FFFF);
        ir = 32'hFFF80000; #1;
        chk("cext zero", if_main.c_sign_extended, 32'h0);

        // Asynchronous reset mid-run drops data and pending bits without a clock.
        @(negedge clk);
        drive(3'b100, 4'd5, 4'd0, 4'd0, 1, 0, 0, 0, 32'hDEADBEEF, 4'd0);
        @(negedge clk);
        drive(3'b100, 4'd6, 4'd0, 4'd0, 0, 0, 0, 1, 32'h0, 4'd0);
        @(negedge clk);
        drive(3'b100, 4'd6, 4'd0, 4'd0, 0, 1, 0, 0, 32'h0, 4'd5);
        #1;
        chk("pre-rst stall", 32'(if_main.stall), 32'h1);
        chk("pre-rst rd2_data", if_main.rd2_data, 32'hDEADBEEF);
        drive(3'b100, 4'd5, 4'd0, 4'd0, 0, 1, 0, 0, 32'h0, 4'd5);
        #1;
        chk("pre-rst bus_out", if_main.bus_out, 32'hDEADBEEF);
        clr = 1'b0;
        #1;
        chk("mid-rst bus_out", if_main.bus_out, 32'h0);
        chk("mid-rst rd2_data", if_main.rd2_data, 32'h0);
        chk("mid-rst bus_out_en", 32'(if_main.bus_out_en), 32'h0);
        chk("mid-rst stall", 32'(if_main.stall), 32'h0);
        @(negedge clk);
        clr = 1'b1;
        drive(3'b100, 4'd6, 4'd0, 4'd0, 0, 1, 0, 0, 32'h0, 4'd5);
        #1;
        chk("post-rst stall", 32'(if_main.stall), 32'h0);
        chk("post-rst rd2_data", if_main.rd2_data, 32'h0);
        chk("post-rst bus_out_en", 32'(if_main.bus_out_en), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/gen_reg_file.md
Name: gen_reg_file

Overview:
- Parametrised successor to the fixed 16 x 32-bit register bank and select/encode logic of the single-bus CPU datapath.
- Decodes Ra/Rb/Rc fields from the IR under Gra/Grb/Grc, writes from the bus on Rin, and drives the bus on Rout/BAout (R0 reads as zero under BAout).
- Adds a second read port for the planned 3-bus datapath, optional write-to-read bypass, and a per-register load-pending scoreboard with a stall output.
- Produces the sign-extended C field.

Parameters:
WIDTH, 32, register/bus width in bits
NREGS, 16, number of registers (2..32, need not be a power of 2)
IR_WIDTH, 32, IR width
RA_LSB, 23, LSB of Ra field in IR
RB_LSB, 19, LSB of Rb field in IR
RC_LSB, 15, LSB of Rc field in IR
C_WIDTH, 19, width of constant field at IR[C_WIDTH-1:0]
ZERO_R0, 1, 1 = R0 reads as 0 under baout
BYPASS, 1, 1 = port-2 read returns same-cycle write data

Ports:
clk  in  1  clock, rising edge
clr  in  1  asynchronous active-low reset
ir  in  IR_WIDTH  instruction register contents
gra  in  1  select Ra field
grb  in  1  select Rb field
grc  in  1  select Rc field
rin  in  1  write bus_in to selected register
rout  in  1  drive selected register onto bus_out
baout  in  1  as rout, but R0 reads as 0 when ZERO_R0=1
bus_in  in  WIDTH  write data from bus
bus_out  out  WIDTH  read data to bus mux
bus_out_en  out  1  bus_out valid (rout|baout with a legal selection)
rd2_idx  in  RW  port-2 register index, RW = clog2(NREGS)
rd2_data  out  WIDTH  port-2 read data
pend_set  in  1  mark selected register load-pending
stall  out  1  read of a pending register requested
illegal_sel  out  1  selected index >= NREGS
c_sign_extended  out  WIDTH  IR[C_WIDTH-1:0] sign-extended to WIDTH

Behaviour:
- Reset: clr low asynchronously clears all registers and all pending bits. bus_out, rd2_data and c_sign_extended follow the zeroed state (0). bus_out_en, stall and illegal_sel are 0 while clr is low.
- Selection: sel_idx = Ra if gra, else Rb if grb, else Rc if grc. Priority is gra > grb > grc. With no gr* asserted there is no selection; rin, rout, baout and pend_set are ignored.
- Field width is RW bits. Index >= NREGS sets illegal_sel (combinational): writes are ignored, reads return 0, bus_out_en = 0.
- Write: on the rising edge with rin and a legal selection, reg[sel_idx] <= bus_in. R0 is writable; only its read under baout is zeroed.
- Bus read: combinational, 0 latency. bus_out = reg[sel_idx], or 0 when baout and sel_idx == 0 and ZERO_R0. rout and baout both high behaves as baout. No bypass on bus_out (single bus cannot carry read and write in one cycle).
- Port 2: rd2_data = reg[rd2_idx], combinational. If BYPASS, rin is high and sel_idx == rd2_idx, rd2_data = bus_in. Out-of-range rd2_idx returns 0.
- Scoreboard:
  - pend_set on the edge sets pending[sel_idx].
  - A write (rin) to a register clears its pending bit.
  - pend_set and rin in the same cycle to the same register: pending ends set.
- stall = (rout|baout) and pending[sel_idx], or port-2 read of a pending register. Combinational. While stall is high, bus_out still shows the stored value and the control unit must hold.
- c_sign_extended: {{(WIDTH-C_WIDTH){ir[C_WIDTH-1]}}, ir[C_WIDTH-1:0]}. Requires C_WIDTH <= WIDTH (elaboration check).
- Reset mid-operation: pending state and data are lost. A write on the same edge as clr release is not captured (reset dominates).

Decomposition:
- Shared package: RW computation (clog2), IR field default positions, default WIDTH/NREGS.
- One sub-module, gen_sel_encode: gr* priority, field extraction, illegal_sel, one-hot write/read enables.
- Register array and scoreboard stay in the top module.

Test Plan:
- Reset: drive clr=0 mid-run after writing R5=0xDEADBEEF -> all reads return 0, stall=0, pending cleared immediately, without waiting for a clock.
- Write/read: ir Ra=3, gra+rin, bus_in=0x12345678, then gra+rout -> bus_out=0x12345678, bus_out_en=1 with zero latency; rd2_idx=3 also shows 0x12345678.
- R0/BAout: write R0=0xFFFF0000 -> rout reads 0xFFFF0000; baout reads 0; ZERO_R0=0 build reads 0xFFFF0000 under baout.
- Priority/illegal:
  - gra+grb with Ra=2, Rb=7 -> register 2 accessed.
  - NREGS=12, Rc=14 with grc+rin -> no write, illegal_sel=1, bus_out=0.
- Scoreboard:
  - pend_set on R4, then rout R4 -> stall=1.
  - rin to R4 (bus_in=0xA5A5A5A5) -> stall clears the next cycle and value reads back.
  - Simultaneous pend_set+rin on R4 -> stall remains 1.
- Bypass/sign-extend:
  - BYPASS=1, rin to R9 with bus_in=0x55 and rd2_idx=9 in the same cycle -> rd2_data=0x55 that cycle.
  - ir[18:0]=0x40000 -> c_sign_extended=0xFFFC0000.
  - ir[18:0]=0x3FFFF -> c_sign_extended=0x0003FFFF.
